// File: rtl/gs232c_bht_tbl.sv
// gs232c_bht_tbl
// Table-side responder for one branch-history predictor table, plus the
// RAM-initialisation sequencer that drives the predictor's raminit interface.
//
// Ports:
//   clock          single clock, all state on the rising edge
//   reset          asynchronous, active-low reset
//   a / ce / en    access address, chip enable, access enable (access = ce && en)
//   wd / we        write data and per-bit write enable
//   rd             registered read data, read-first, one-cycle latency
//   init_req       single-cycle pulse requesting a new initialisation sweep
//   raminit_valid  high for every sweep cycle
//   raminit_index  sweep index, 0 whenever raminit_valid is low
//   init_done      high once a sweep has completed and none is running
module gs232c_bht_tbl #(
    parameter int unsigned AW            = 8,
    parameter int unsigned DW            = 32,
    parameter int unsigned IW            = 8,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] a,
    input  logic          ce,
    input  logic          en,
    input  logic [DW-1:0] wd,
    input  logic [DW-1:0] we,
    output logic [DW-1:0] rd,
    input  logic          init_req,
    output logic          raminit_valid,
    output logic [IW-1:0] raminit_index,
    output logic          init_done
);

    localparam int unsigned   DEPTH    = 2 ** AW;
    localparam logic [IW-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] cnt;
    logic [IW-1:0] cnt_nxt;
    logic          acc;

    logic [DW-1:0] mem [DEPTH];

    assign acc = ce && en;

    // Storage has no reset; only the bits selected by we are modified.
    always_ff @(posedge clock) begin
        if (acc) begin
            mem[a] <= (mem[a] & ~we) | (wd & we);
        end
    end

    // Read-first: rd captures the entry as it was before this edge's write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd <= '0;
        end else if (acc) begin
            rd <= mem[a];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (INIT_ON_RESET || init_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                // init_req is deliberately ignored while sweeping.
                if (cnt == LAST_IDX) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + IW'(1);
                end
            end
            DONE: begin
                if (init_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Status outputs are registered from the next-state decode so they line
    // up with the state they describe; cnt is held at 0 outside SWEEP, so
    // it can drive raminit_index directly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            raminit_valid <= 1'b0;
            init_done     <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            raminit_valid <= (state_nxt == SWEEP);
            init_done     <= (state_nxt == DONE);
        end
    end

    assign raminit_index = cnt;

endmodule

// File: doc/gs232c_bht_tbl.md
Name: gs232c_bht_tbl

Overview:
Table-side responder for the branch-history predictor's table ports, with the RAM-initialisation sequencer that drives the predictor's raminit interface.
- Storage: a synchronous single-port RAM with per-bit write enables and one-cycle read latency. It answers the a/ce/en/wd/we/rd port group.
- Initialisation: after reset, or on request, the block sweeps raminit_index across every predictor index with raminit_valid high. The predictor turns that sweep into all-zero writes.
- One instance is used per table (cnt0_lo/hi, cnt1_lo/hi, tag1). Only the instance tied to the widest index drives the raminit outputs.

Parameters:
AW, 8, RAM address width; depth = 2^AW entries.
DW, 32, data width; we is per-bit, DW bits.
IW, 8, raminit_index width; sweep length = 2^IW cycles.
INIT_ON_RESET, 1, 1 = start the sweep automatically when reset deasserts; 0 = wait for init_req.

Ports:
clock  in  1  single clock; all state on the rising edge.
reset  in  1  asynchronous, active-low reset.
a  in  AW  access address.
ce  in  1  chip enable.
en  in  1  access enable; an access occurs only when ce && en.
wd  in  DW  write data.
we  in  DW  per-bit write enable; bit i writes wd[i].
rd  out  DW  read data, registered.
init_req  in  1  single-cycle pulse requesting a new sweep.
raminit_valid  out  1  high for every sweep cycle.
raminit_index  out  IW  sweep index.
init_done  out  1  level; high once a sweep has completed and no new sweep is running.

Behaviour:
- Reset (reset low, asynchronous):
  - rd=0, raminit_valid=0, raminit_index=0, init_done=0, FSM=IDLE.
  - RAM contents are not reset.
- Access cycle: acc = ce && en.
  - On the clock edge with acc, for each bit i with we[i]=1: mem[a][i] <= wd[i]. Bits with we[i]=0 are unchanged.
  - On the same edge with acc, rd <= mem[a] as it was before the write (read-first). The predictor forwards same-cycle modifications itself.
  - Without acc, rd holds its previous value. The predictor samples rd only in the cycle after its request.
  - we is ignored when acc=0.
  - Read latency is exactly 1 cycle; there is no back-pressure and an access is accepted every cycle.
- Init FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on the first clock edge after reset deasserts when INIT_ON_RESET=1, or on init_req.
  - SWEEP: raminit_valid=1 and raminit_index=cnt. cnt starts at 0 and increments by 1 per cycle.
  - SWEEP -> DONE on the edge where cnt = 2^IW-1, so exactly 2^IW valid cycles. cnt wraps to 0 and raminit_valid drops to 0 on that edge.
  - DONE: init_done=1. init_req returns to SWEEP, clearing init_done in the same edge and restarting cnt at 0.
  - init_req during SWEEP is ignored; no restart and no queueing.
- raminit_index and raminit_valid are registered outputs; raminit_index is 0 whenever raminit_valid=0.
- The RAM keeps honouring its ports during SWEEP. The predictor drives we all-ones and wd=0 while raminit_valid=1, so every entry with index < 2^AW reads 0 after the sweep.
- When IW > AW, sweep indices alias onto the same entries; this is harmless (repeated zero writes).
- Reset asserted mid-sweep: the sweep aborts immediately. After deassert, the sweep restarts from index 0 when INIT_ON_RESET=1, otherwise the FSM stays in IDLE.
- Simultaneous acc and init_req: both take effect; they are independent.

Test Plan:
1. Reset release, INIT_ON_RESET=1, IW=8 -> raminit_valid high for exactly 256 consecutive cycles with index 0,1,...,255. Then valid=0, index=0, and init_done=1 from the following cycle.
2. Write a=0x12, wd=0xDEADBEEF, we=all-ones; then read a=0x12 -> rd=0xDEADBEEF one cycle after the read edge.
3. Partial write to a=0x12, wd=0x00000000, we=0x0000FF00 -> subsequent read returns 0xDEAD00EF.
4. Same-edge write 0x11111111 and read at a=0x05, which previously held 0x22222222 -> rd=0x22222222; the next read of 0x05 returns 0x11111111.
5. Assert reset at sweep index 100, release 3 cycles later -> rd=0 while reset is low; sweep restarts at index 0 and runs 256 cycles. init_req pulsed at index 50 of that sweep has no effect.
6. In DONE with ce=1, en=0, we=all-ones at a=0x12 -> no write and rd unchanged. Then init_req -> init_done drops on the next edge and a new 256-cycle sweep begins.
